// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache and D-cache.
// One transaction at a time; grant, busy-wait handshake, one-cycle completion, then idle.
module mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_READ,
    input  logic [ADDR_W-1:0] I_ADDRESS,
    output logic [DATA_W-1:0] I_READDATA,
    output logic              I_BUSYWAIT,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [ADDR_W-1:0] D_ADDRESS,
    input  logic [DATA_W-1:0] D_WRITEDATA,
    output logic [DATA_W-1:0] D_READDATA,
    output logic              D_BUSYWAIT,
    output logic              M_READ,
    output logic              M_WRITE,
    output logic [ADDR_W-1:0] M_ADDRESS,
    output logic [DATA_W-1:0] M_WRITEDATA,
    input  logic [DATA_W-1:0] M_READDATA,
    input  logic              M_BUSYWAIT
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_t;

    state_t state, state_nxt;
    logic   started, started_nxt;
    logic   last_d, last_d_nxt;
    logic   own_d, own_d_nxt;
    logic   cmd_wr, cmd_wr_nxt;
    logic   req_i, req_d, granted, finish;

    assign req_i   = I_READ;
    assign req_d   = D_READ | D_WRITE;
    assign granted = (state == GNT_I) || (state == GNT_D);
    assign finish  = granted && started && !M_BUSYWAIT;

    always_comb begin
        state_nxt   = state;
        started_nxt = started;
        last_d_nxt  = last_d;
        own_d_nxt   = own_d;
        cmd_wr_nxt  = cmd_wr;
        unique case (state)
            IDLE: begin
                if (req_i && (!req_d || last_d)) begin
                    state_nxt  = GNT_I;
                    own_d_nxt  = 1'b0;
                    last_d_nxt = 1'b0;
                    cmd_wr_nxt = 1'b0;
                end else if (req_d) begin
                    state_nxt  = GNT_D;
                    own_d_nxt  = 1'b1;
                    last_d_nxt = 1'b1;
                    // write wins when both D commands are asserted; latched so a dropped request still completes
                    cmd_wr_nxt = D_WRITE;
                end
            end
            GNT_I, GNT_D: begin
                if (finish) begin
                    state_nxt   = DONE;
                    started_nxt = 1'b0;
                end else if (M_BUSYWAIT) begin
                    started_nxt = 1'b1;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            started    <= 1'b0;
            last_d     <= 1'b1;
            own_d      <= 1'b0;
            cmd_wr     <= 1'b0;
            I_READDATA <= '0;
            D_READDATA <= '0;
        end else begin
            state   <= state_nxt;
            started <= started_nxt;
            last_d  <= last_d_nxt;
            own_d   <= own_d_nxt;
            cmd_wr  <= cmd_wr_nxt;
            if (finish && !cmd_wr) begin
                if (own_d) D_READDATA <= M_READDATA;
                else       I_READDATA <= M_READDATA;
            end
        end
    end

    // Memory command decodes from state so an async reset drops it without a clock edge.
    always_comb begin
        M_READ      = 1'b0;
        M_WRITE     = 1'b0;
        M_ADDRESS   = '0;
        M_WRITEDATA = '0;
        if (state == GNT_I) begin
            M_READ    = 1'b1;
            M_ADDRESS = I_ADDRESS;
        end else if (state == GNT_D) begin
            M_READ      = !cmd_wr;
            M_WRITE     = cmd_wr;
            M_ADDRESS   = D_ADDRESS;
            M_WRITEDATA = D_WRITEDATA;
        end
    end

    assign I_BUSYWAIT = req_i & !((state == DONE) && !own_d);
    assign D_BUSYWAIT = req_d & !((state == DONE) && own_d);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized dual-stream traffic
// scored against a transaction-level memory image and round-robin grant rule.
module tb_mem_arbiter;

    logic        CLK, RESET;
    logic        I_READ, I_BUSYWAIT;
    logic [5:0]  I_ADDRESS;
    logic [31:0] I_READDATA;
    logic        D_READ, D_WRITE, D_BUSYWAIT;
    logic [5:0]  D_ADDRESS;
    logic [31:0] D_WRITEDATA, D_READDATA;
    logic        M_READ, M_WRITE, M_BUSYWAIT;
    logic [5:0]  M_ADDRESS;
    logic [31:0] M_WRITEDATA, M_READDATA;

    mem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDRESS(M_ADDRESS), .M_WRITEDATA(M_WRITEDATA),
        .M_READDATA(M_READDATA), .M_BUSYWAIT(M_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    int unsigned lat      = 5;
    bit          rand_lat = 1'b0;
    int unsigned mcnt;
    bit          cool, mwr;
    logic [5:0]  maddr;
    int          order[$];

    // Memory: registered busy for a programmable number of cycles, ignores the command on the exit edge.
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            M_BUSYWAIT <= 1'b0;
            M_READDATA <= '0;
            mcnt       <= 0;
            cool       <= 1'b0;
        end else if (cool) begin
            cool <= 1'b0;
        end else if (M_BUSYWAIT) begin
            if (mcnt > 1) mcnt <= mcnt - 1;
            else begin
                M_BUSYWAIT <= 1'b0;
                cool       <= 1'b1;
                if (!mwr) M_READDATA <= mem[maddr];
            end
        end else if (M_READ || M_WRITE) begin
            M_BUSYWAIT <= 1'b1;
            M_READDATA <= $urandom;
            mcnt       <= rand_lat ? $urandom_range(1, 6) : lat;
            maddr      <= M_ADDRESS;
            mwr        <= M_WRITE;
            if (M_WRITE) mem[M_ADDRESS] <= M_WRITEDATA;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        #2 RESET = 1'b0;
        #2 RESET = 1'b1;
        tick();
    endtask

    task automatic i_stream(input int n, input bit rnd);
        for (int k = 0; k < n; k++) begin
            logic [5:0] a;
            int c;
            if (rnd) repeat ($urandom_range(0, 3)) tick();
            a = 6'($urandom_range(0, 31));
            I_ADDRESS = a;
            I_READ    = 1'b1;
            c = 0;
            do begin tick(); c++; end while (I_BUSYWAIT && c < 400);
            chk("i_timeout", 32'(I_BUSYWAIT), 0);
            chk("i_rdata", I_READDATA, ref_mem[a]);
            order.push_back(0);
            I_READ = 1'b0;
            tick();
        end
    endtask

    task automatic d_stream(input int n, input bit rnd);
        for (int k = 0; k < n; k++) begin
            logic [5:0]  a;
            logic [31:0] wd, prev;
            int op, c;
            if (rnd) repeat ($urandom_range(0, 3)) tick();
            a  = 6'($urandom_range(32, 63));
            wd = $urandom;
            op = rnd ? $urandom_range(0, 2) : 0;
            prev = D_READDATA;
            D_ADDRESS   = a;
            D_WRITEDATA = wd;
            D_READ      = (op != 1);
            D_WRITE     = (op != 0);
            c = 0;
            do begin tick(); c++; end while (D_BUSYWAIT && c < 400);
            chk("d_timeout", 32'(D_BUSYWAIT), 0);
            if (op == 0) chk("d_rdata", D_READDATA, ref_mem[a]);
            else begin
                ref_mem[a] = wd;
                chk("d_wr_keeps_rdata", D_READDATA, prev);
            end
            order.push_back(1);
            D_READ  = 1'b0;
            D_WRITE = 1'b0;
            tick();
        end
    endtask

    initial begin
        int c, i_done, d_done;
        bit d_early, saw_wr, both_cmd;
        logic [5:0]  wa;
        logic [31:0] wdat, prev;

        for (int i = 0; i < 64; i++) begin
            mem[i]     <= 32'(i) * 32'h9E37_79B1;
            ref_mem[i]  = 32'(i) * 32'h9E37_79B1;
        end
        mem[18]     <= 32'hDEAD_BEEF;
        ref_mem[18]  = 32'hDEAD_BEEF;
        RESET = 1'b0;
        I_READ = 1'b1; I_ADDRESS = 6'h12;
        D_READ = 1'b0; D_WRITE = 1'b0; D_ADDRESS = '0; D_WRITEDATA = '0;

        // Reset sweep
        repeat (2) tick();
        chk("rst_i_busy", 32'(I_BUSYWAIT), 1);
        chk("rst_m_read", 32'(M_READ), 0);
        chk("rst_i_rdata", I_READDATA, 0);
        chk("rst_d_rdata", D_READDATA, 0);
        chk("rst_m_addr", 32'(M_ADDRESS), 0);
        RESET = 1'b1;
        tick();
        chk("rst_rel_m_read", 32'(M_READ), 1);
        c = 0;
        while (I_BUSYWAIT && c < 400) begin tick(); c++; end
        chk("rst_rel_done", 32'(I_BUSYWAIT), 0);
        I_READ = 1'b0;
        tick();

        // Single I read, latency 5
        pulse_reset();
        prev = D_READDATA;
        I_ADDRESS = 6'h12; I_READ = 1'b1;
        c = 0;
        do begin
            tick(); c++;
            if (c == 1) begin
                chk("i1_m_addr", 32'(M_ADDRESS), 32'h12);
                chk("i1_m_read", 32'(M_READ), 1);
            end
        end while (I_BUSYWAIT && c < 400);
        chk("i1_stall", 32'(c), 8);
        chk("i1_rdata", I_READDATA, 32'hDEAD_BEEF);
        chk("i1_d_unch", D_READDATA, prev);
        I_READ = 1'b0;
        tick();
        chk("idle_m_addr", 32'(M_ADDRESS), 0);

        // Simultaneous I read and D write after reset
        pulse_reset();
        I_ADDRESS = 6'h05; I_READ = 1'b1;
        D_ADDRESS = 6'h3F; D_WRITEDATA = 32'hA5A5_A5A5; D_WRITE = 1'b1;
        c = 0; i_done = 0; d_done = 0; d_early = 0; saw_wr = 0; both_cmd = 0;
        wa = '0; wdat = '0;
        while (d_done == 0 && c < 400) begin
            tick(); c++;
            if (M_WRITE && !saw_wr) begin saw_wr = 1; wa = M_ADDRESS; wdat = M_WRITEDATA; end
            if (M_WRITE && M_READ) both_cmd = 1;
            if (i_done == 0 && !D_BUSYWAIT) d_early = 1;
            if (i_done == 0 && !I_BUSYWAIT) begin
                i_done = c;
                chk("tie_i_rdata", I_READDATA, ref_mem[5]);
                I_READ = 1'b0;
            end
            if (!D_BUSYWAIT) d_done = c;
        end
        chk("tie_i_stall", 32'(i_done), 8);
        chk("tie_d_stall", 32'(d_done), 17);
        chk("tie_d_held", 32'(d_early), 0);
        chk("tie_saw_wr", 32'(saw_wr), 1);
        chk("tie_wr_addr", 32'(wa), 32'h3F);
        chk("tie_wr_data", wdat, 32'hA5A5_A5A5);
        chk("tie_cmd_excl", 32'(both_cmd), 0);
        ref_mem[63] = 32'hA5A5_A5A5;
        D_WRITE = 1'b0;
        tick();

        // Continuous contention: grants alternate starting with I
        pulse_reset();
        order.delete();
        fork
            i_stream(3, 1'b0);
            d_stream(3, 1'b0);
        join
        chk("rr_count", 32'(order.size()), 6);
        for (int k = 0; k < order.size(); k++) chk($sformatf("rr_order%0d", k), 32'(order[k]), 32'(k % 2));

        // D_READ and D_WRITE together -> write
        prev = D_READDATA;
        D_ADDRESS = 6'h20; D_WRITEDATA = 32'h0BAD_F00D; D_READ = 1'b1; D_WRITE = 1'b1;
        tick();
        chk("rw_m_write", 32'(M_WRITE), 1);
        chk("rw_m_read", 32'(M_READ), 0);
        c = 0;
        while (D_BUSYWAIT && c < 400) begin tick(); c++; end
        chk("rw_done", 32'(D_BUSYWAIT), 0);
        chk("rw_rdata_unch", D_READDATA, prev);
        ref_mem[32] = 32'h0BAD_F00D;
        D_READ = 1'b0; D_WRITE = 1'b0;
        tick();
        D_ADDRESS = 6'h20; D_READ = 1'b1;
        c = 0;
        do begin tick(); c++; end while (D_BUSYWAIT && c < 400);
        chk("rw_readback", D_READDATA, 32'h0BAD_F00D);
        D_READ = 1'b0;
        tick();

        // Randomized dual-stream traffic
        rand_lat = 1'b1;
        fork
            i_stream(20, 1'b1);
            d_stream(20, 1'b1);
        join
        rand_lat = 1'b0;

        // Async reset during the 3rd busy cycle of a D write
        lat = 6;
        D_ADDRESS = 6'h2A; D_WRITEDATA = 32'h1234_5678; D_WRITE = 1'b1;
        tick();
        chk("ar_gnt", 32'(M_WRITE), 1);
        repeat (3) tick();
        chk("ar_busy3", 32'(M_BUSYWAIT & M_WRITE), 1);
        #2 RESET = 1'b0;
        #1;
        chk("ar_m_write", 32'(M_WRITE), 0);
        chk("ar_m_addr", 32'(M_ADDRESS), 0);
        chk("ar_d_busy", 32'(D_BUSYWAIT), 1);
        chk("ar_d_rdata", D_READDATA, 0);
        #2 RESET = 1'b1;
        tick();
        chk("ar_regrant", 32'(M_WRITE), 1);
        chk("ar_regrant_addr", 32'(M_ADDRESS), 32'h2A);
        c = 0;
        while (D_BUSYWAIT && c < 400) begin tick(); c++; end
        chk("ar_done", 32'(D_BUSYWAIT), 0);
        ref_mem[42] = 32'h1234_5678;
        D_WRITE = 1'b0;
        tick();
        D_ADDRESS = 6'h2A; D_READ = 1'b1;
        c = 0;
        do begin tick(); c++; end while (D_BUSYWAIT && c < 400);
        chk("ar_readback", D_READDATA, 32'h1234_5678);
        D_READ = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
